flags_reg: RTL
==============

Name: flags_reg

Overview:
- Architectural FLAGS register for the S186 core, on the producing side of the flag word that the jump-condition logic consumes.
- Merges ALU flag results, POPF/IRET/SAHF writes and single-flag ops (CLC/STC/CMC/CLI/STI/CLD/STD, interrupt entry) into one registered 16-bit word.
- Tracks the STI/POP SS interrupt shadow and the single-step (TF) trap timing at instruction boundaries.
- Provides irq_enable and trap_pending to the microcode sequencer.

Parameters:
- FIXED_ONES, 16'hF002, bits forced to 1 on every write (80186: bits 15:12 and bit 1).
- WRITABLE_MASK, 16'h0FD5, writable bits: OF DF IF TF SF ZF AF PF CF.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- alu_flags  in  16  flag result from ALU
- alu_mask  in  16  bits of alu_flags to commit
- alu_valid  in  1  commit ALU flags this cycle
- wr_value  in  16  POPF/IRET/SAHF source
- wr_valid  in  1  full write
- wr_low_only  in  1  with wr_valid: SAHF, update SF ZF AF PF CF only
- flag_op  in  3  0 CLC, 1 STC, 2 CMC, 3 CLI, 4 STI, 5 CLD, 6 STD, 7 INT_ENTRY (clear IF and TF)
- flag_op_valid  in  1  apply flag_op
- shadow_req  in  1  MOV/POP SS executed: arm shadow
- retire  in  1  one-cycle pulse at instruction end
- flags_out  out  16  registered FLAGS
- irq_enable  out  1  IF set and no shadow
- trap_pending  out  1  one-cycle single-step trap request

Behaviour:
- Reset (clk edge with reset_n=0): flags_out=16'hF002; shadow=IDLE; tf_at_start=0; trap_pending=0; irq_enable=0. Reset mid-shadow or with a trap pending discards both.
- All updates take effect at the next clk edge; latency 1. flags_out is always (next & WRITABLE_MASK) | FIXED_ONES. Bits 3 and 5 read 0.
- Priority when several sources are valid in one cycle: wr_valid > flag_op_valid > alu_valid. Lower-priority sources are fully ignored that cycle. The bench flags any overlap as a warning.
- ALU: next = (flags & ~alu_mask) | (alu_flags & alu_mask).
- wr_low_only: mask 16'h00D5. Otherwise mask WRITABLE_MASK.
- CMC: CF inverted. INT_ENTRY clears IF[9] and TF[8].
- Interrupt shadow FSM:
  - IDLE -> PEND on STI applied while IF=0, or on shadow_req.
  - PEND -> ACTIVE on retire.
  - ACTIVE -> IDLE on retire.
  - CLI or INT_ENTRY in any state -> IDLE.
  - STI while IF=1: no state change.
  - shadow_req in ACTIVE -> PEND, which re-arms the shadow.
- irq_enable = IF & (state==IDLE), registered; it reflects the flags and state after the current edge's update.
- Single-step trap:
  - On each retire: trap_pending <= tf_at_start for one cycle; tf_at_start <= TF value after that edge's update.
  - Result: an instruction that sets TF (POPF) does not trap; the following instruction does.
  - An instruction that clears TF still traps if TF was set when it began.
  - trap_pending is otherwise 0.
- A retire in the same cycle as a flag update: the update applies first, and tf_at_start samples the updated TF.

Decomposition:
- Shared core package: the existing CF/PF/AF/ZF/SF/TF/IF/DF/OF _IDX constants; a flag_op_t enum (CLC..INT_ENTRY); a shadow_state_t enum {IDLE, PEND, ACTIVE}; the FLAGS_RESET, FLAGS_WRITABLE and SAHF_MASK constants.
- Sub-module: irq_shadow_fsm (state plus irq_enable). Flag merge and trap logic stay in flags_reg.

Test Plan:
- Reset, then idle 3 cycles -> flags_out=16'hF002, irq_enable=0, trap_pending=0. Assert reset_n=0 during PEND -> state IDLE, flags 16'hF002.
- alu_valid, alu_flags=16'hFFFF, alu_mask=16'h08D5 -> flags_out=16'hF8D7 next cycle. Then CMC -> 16'hF8D6.
- wr_valid with wr_low_only, wr_value=16'hFF00 from 16'hFFD7 state -> bits 7,6,4,2,0 cleared, flags_out=16'hFF02. The same write without wr_low_only, value 16'h0000 -> 16'hF002.
- IF=0, STI then retire -> irq_enable stays 0. Second retire -> irq_enable=1. Repeat, with CLI issued during ACTIVE -> irq_enable=0, state IDLE.
- POPF wr_value=16'h0100 with retire -> no trap_pending. Next retire -> trap_pending=1 for exactly one cycle. INT_ENTRY -> TF=0, and no further traps after the next retire.
- wr_valid(16'h0001) together with alu_valid(mask 16'h0001, flags 0) -> CF=1, because the write wins.

Source files
------------

// File: rtl/flags_reg_pkg.sv
// Shared FLAGS definitions for the S186 core: bit positions, single-flag
// operation codes, interrupt-shadow states and the fixed/writable masks.
package flags_reg_pkg;

  localparam int CF_IDX = 0;
  localparam int PF_IDX = 2;
  localparam int AF_IDX = 4;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int TF_IDX = 8;
  localparam int IF_IDX = 9;
  localparam int DF_IDX = 10;
  localparam int OF_IDX = 11;

  localparam logic [15:0] FLAGS_RESET    = 16'hF002;
  localparam logic [15:0] FLAGS_WRITABLE = 16'h0FD5;
  localparam logic [15:0] SAHF_MASK      = 16'h00D5;

  typedef enum logic [2:0] {
    FOP_CLC       = 3'd0,
    FOP_STC       = 3'd1,
    FOP_CMC       = 3'd2,
    FOP_CLI       = 3'd3,
    FOP_STI       = 3'd4,
    FOP_CLD       = 3'd5,
    FOP_STD       = 3'd6,
    FOP_INT_ENTRY = 3'd7
  } flag_op_t;

  typedef enum logic [1:0] {
    SH_IDLE   = 2'd0,
    SH_PEND   = 2'd1,
    SH_ACTIVE = 2'd2
  } shadow_state_t;

endpackage

// File: rtl/flags_reg_irq_shadow_fsm.sv
// Interrupt shadow after STI / MOV SS / POP SS; owns the registered irq_enable.
module irq_shadow_fsm
  import flags_reg_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_shadow_req,
  input  logic i_sti_arm,
  input  logic i_retire,
  input  logic i_if_next,
  output logic o_irq_enable
);

  shadow_state_t r_state;
  shadow_state_t w_state_next;
  logic          r_irq_enable;

  // Clearing IF dominates; a new arm request beats the retire advance so the
  // shadow always covers the instruction that follows the arming one.
  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = SH_IDLE;
    end else if (i_shadow_req) begin
      w_state_next = SH_PEND;
    end else if (i_sti_arm && (r_state == SH_IDLE)) begin
      w_state_next = SH_PEND;
    end else if (i_retire) begin
      case (r_state)
        SH_PEND:   w_state_next = SH_ACTIVE;
        SH_ACTIVE: w_state_next = SH_IDLE;
        default:   w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= SH_IDLE;
      r_irq_enable <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_irq_enable <= i_if_next && (w_state_next == SH_IDLE);
    end
  end

  assign o_irq_enable = r_irq_enable;

endmodule

// File: rtl/flags_reg.sv
// Architectural FLAGS register: merges full/SAHF writes, single-flag ops and
// ALU results, and generates the single-step trap at instruction boundaries.
module flags_reg
  import flags_reg_pkg::*;
#(
  parameter logic [15:0] FIXED_ONES    = FLAGS_RESET,
  parameter logic [15:0] WRITABLE_MASK = FLAGS_WRITABLE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] alu_flags,
  input  logic [15:0] alu_mask,
  input  logic        alu_valid,
  input  logic [15:0] wr_value,
  input  logic        wr_valid,
  input  logic        wr_low_only,
  input  logic [2:0]  flag_op,
  input  logic        flag_op_valid,
  input  logic        shadow_req,
  input  logic        retire,
  output logic [15:0] flags_out,
  output logic        irq_enable,
  output logic        trap_pending
);

  logic [15:0] r_flags;
  logic        r_tf_at_start;
  logic        r_trap_pending;

  logic [15:0] w_wr_mask;
  logic [15:0] w_flags_merge;
  logic [15:0] w_flags_next;
  logic        w_op_applied;
  logic        w_clear_shadow;
  logic        w_sti_arm;
  flag_op_t    w_op;

  assign w_op         = flag_op_t'(flag_op);
  assign w_wr_mask    = wr_low_only ? SAHF_MASK : WRITABLE_MASK;
  // A full write in the same cycle suppresses any single-flag op.
  assign w_op_applied = flag_op_valid && !wr_valid;

  always_comb begin
    w_flags_merge = r_flags;
    if (wr_valid) begin
      w_flags_merge = (r_flags & ~w_wr_mask) | (wr_value & w_wr_mask);
    end else if (flag_op_valid) begin
      case (w_op)
        FOP_CLC: w_flags_merge[CF_IDX] = 1'b0;
        FOP_STC: w_flags_merge[CF_IDX] = 1'b1;
        FOP_CMC: w_flags_merge[CF_IDX] = ~r_flags[CF_IDX];
        FOP_CLI: w_flags_merge[IF_IDX] = 1'b0;
        FOP_STI: w_flags_merge[IF_IDX] = 1'b1;
        FOP_CLD: w_flags_merge[DF_IDX] = 1'b0;
        FOP_STD: w_flags_merge[DF_IDX] = 1'b1;
        FOP_INT_ENTRY: begin
          w_flags_merge[IF_IDX] = 1'b0;
          w_flags_merge[TF_IDX] = 1'b0;
        end
        default: w_flags_merge = r_flags;
      endcase
    end else if (alu_valid) begin
      w_flags_merge = (r_flags & ~alu_mask) | (alu_flags & alu_mask);
    end
  end

  assign w_flags_next   = (w_flags_merge & WRITABLE_MASK) | FIXED_ONES;
  assign w_clear_shadow = w_op_applied && ((w_op == FOP_CLI) || (w_op == FOP_INT_ENTRY));
  assign w_sti_arm      = w_op_applied && (w_op == FOP_STI) && !r_flags[IF_IDX];

  // tf_at_start samples TF after this edge's update, so POPF setting TF
  // only traps on the following instruction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_flags        <= FIXED_ONES;
      r_tf_at_start  <= 1'b0;
      r_trap_pending <= 1'b0;
    end else begin
      r_flags <= w_flags_next;
      if (retire) begin
        r_trap_pending <= r_tf_at_start;
        r_tf_at_start  <= w_flags_next[TF_IDX];
      end else begin
        r_trap_pending <= 1'b0;
      end
    end
  end

  irq_shadow_fsm u_shadow (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_clear_shadow),
    .i_shadow_req (shadow_req),
    .i_sti_arm    (w_sti_arm),
    .i_retire     (retire),
    .i_if_next    (w_flags_next[IF_IDX]),
    .o_irq_enable (irq_enable)
  );

  assign flags_out    = r_flags;
  assign trap_pending = r_trap_pending;

endmodule
